srl_pipe32: RTL and testbench

Five-stage pipelined 32-bit shifter with valid/ready handshakes on both sides. It wraps the by-16, by-8, by-4, by-2 and by-1 shift stages with one pipeline register each, so a shift operation completes in five cycles at one result per cycle. It sits between the ALU operand-select logic (upstream) and the ALU result mux (downstream), and replaces the single-cycle combinational shift path when the shift must be registered.

---
 rtl/srl_pipe32_if.sv | 24 ++
 rtl/srl_pipe32.sv | 93 +++++++++
 tb/tb_srl_pipe32.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/srl_pipe32_if.sv
// Handshake and data bundle between the operand-select logic, the
// pipelined shifter and the ALU result mux.
interface srl_pipe32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  // Shifter side: consumes operands and downstream ready, produces results.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out
  );

  // Environment side: offers operands and consumes results.
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out
  );
endinterface

// File: rtl/srl_pipe32.sv
// Five-stage pipelined 32-bit shifter (SRL / SLL / SRA). Stage k applies
// the shift by 16>>k when the matching bit of the shift amount is set.
// Each stage holds valid, data, amount and op; a stage advances whenever
// it is empty or the stage behind it advances, so bubbles collapse.
module srl_pipe32 (
  input  logic        clk,
  input  logic        reset,
  srl_pipe32_if.slave bus
);
  localparam int         STAGES = 5;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // Conditional shift for one stage; op 00 and the unused 11 both give SRL.
  // Arithmetic right shift refills from bit 31, which earlier right shifts
  // never change, so it always matches the original operand's sign.
  function automatic logic [31:0] shift_step(input logic [31:0] d,
                                             input logic [1:0]  o,
                                             input logic        en,
                                             input int          n);
    logic signed [31:0] ds;
    logic [31:0]        r;
    ds = d;
    r  = d;
    if (en) begin
      case (o)
        OP_SLL:  r = d << n;
        OP_SRA:  r = ds >>> n;
        default: r = d >> n;
      endcase
    end
    return r;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic        vld_q;
    logic [31:0] dat_q;
    logic [4:0]  amt_q;
    logic [1:0]  op_q;
    logic        adv;
    logic        src_vld;
    logic [31:0] src_dat;
    logic [4:0]  src_amt;
    logic [1:0]  src_op;
    logic [31:0] dat_d;

    if (k == 0) begin : g_src
      assign src_vld = bus.in_valid;
      assign src_dat = bus.a;
      assign src_amt = bus.b;
      assign src_op  = bus.op;
    end else begin : g_src
      assign src_vld = g_stg[k-1].vld_q;
      assign src_dat = g_stg[k-1].dat_q;
      assign src_amt = g_stg[k-1].amt_q;
      assign src_op  = g_stg[k-1].op_q;
    end

    // Ready chain runs combinationally from out_ready back to in_ready.
    if (k == STAGES - 1) begin : g_adv
      assign adv = !vld_q | bus.out_ready;
    end else begin : g_adv
      assign adv = !vld_q | g_stg[k+1].adv;
    end

    assign dat_d = shift_step(src_dat, src_op, src_amt[4-k], 16 >> k);

    // Stage register: loads on advance, otherwise holds everything.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        amt_q <= '0;
        op_q  <= '0;
      end else if (adv) begin
        vld_q <= src_vld;
        dat_q <= dat_d;
        amt_q <= src_amt;
        op_q  <= src_op;
      end
    end

    // The final stage's amount and op are retained for observability only.
    if (k == STAGES - 1) begin : g_tail
      logic unused_tail;
      assign unused_tail = ^{amt_q, op_q};
    end
  end

  assign bus.in_ready  = g_stg[0].adv;
  assign bus.out_valid = g_stg[STAGES-1].vld_q;
  assign bus.out       = g_stg[STAGES-1].dat_q;
endmodule

// File: tb/tb_srl_pipe32.sv
// Directed self-checking bench for srl_pipe32.
module tb_srl_pipe32;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  srl_pipe32_if bus ();

  srl_pipe32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one op with out_ready high, measure edges to out_valid, check result.
  task automatic run_one(input string tag, input logic [31:0] av, input logic [4:0] bv,
                         input logic [1:0] opv, input logic [31:0] exp);
    int n;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.op       = opv;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd5);
    chk({tag, "_out"}, bus.out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    logic        seen;
    logic [31:0] bp_exp;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", bus.out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);

    // Single operations
    run_one("srl8",  32'h80000000, 5'd8,  2'b00, 32'h00800000);
    run_one("sra8",  32'h80000000, 5'd8,  2'b10, 32'hFF800000);
    run_one("sll31", 32'h00000001, 5'd31, 2'b01, 32'h80000000);

    // Boundary shift amounts
    run_one("b0",    32'hDEADBEEF, 5'd0,  2'b10, 32'hDEADBEEF);
    run_one("sra31", 32'h7FFFFFFF, 5'd31, 2'b10, 32'h00000000);
    run_one("srl31", 32'hFFFFFFFF, 5'd31, 2'b00, 32'h00000001);
    run_one("op11",  32'h12345678, 5'd4,  2'b11, 32'h01234567);

    // Back-to-back streaming
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c >= 5 && c < 13) begin
        chk("strm_vld", 32'(bus.out_valid), 32'd1);
        chk("strm_out", bus.out, 32'hF0000000 >> (c - 5));
      end else begin
        chk("strm_idle", 32'(bus.out_valid), 32'd0);
      end
      if (c < 8) begin
        chk("strm_rdy", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = 32'hF0000000;
        bus.b        = 5'(c);
        bus.op       = 2'b00;
      end else begin
        bus.in_valid = 1'b0;
      end
    end

    // Backpressure: offer continuously with out_ready low
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 5) begin
        chk("bp_full_rdy", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_vld", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_out", bus.out, 32'h00000200);
      end else begin
        chk("bp_fill_rdy", 32'(bus.in_ready), 32'd1);
      end
      bus.in_valid = 1'b1;
      bus.a        = 32'h100 + 32'(acc);
      bus.b        = 5'd1;
      bus.op       = 2'b01;
      if (bus.in_ready) acc++;
    end
    chk("bp_count", 32'(acc), 32'd5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_d0_vld", 32'(bus.out_valid), 32'd1);
    chk("bp_d0_out", bus.out, 32'h00000200);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      bp_exp = 32'h200 + 32'(2 * k);
      chk("bp_drain_vld", 32'(bus.out_valid), 32'd1);
      chk("bp_drain_out", bus.out, bp_exp);
    end
    @(negedge clk);
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Bubble collapse
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 32'h0000FFFF;
    bus.b         = 5'd16;
    bus.op        = 2'b01;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bub_rdyB", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = 32'h80000000;
    bus.b        = 5'd2;
    bus.op       = 2'b10;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("bub_A_vld", 32'(bus.out_valid), 32'd1);
    chk("bub_A_out", bus.out, 32'hFFFF0000);
    chk("bub_rdy", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bub_B_vld", 32'(bus.out_valid), 32'd1);
    chk("bub_B_out", bus.out, 32'hE0000000);
    @(negedge clk);
    chk("bub_empty", 32'(bus.out_valid), 32'd0);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'hA0 + 32'(i);
      bus.b        = 5'd0;
      bus.op       = 2'b00;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rm_vld", 32'(bus.out_valid), 32'd0);
    chk("rm_out", bus.out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rm_stale", 32'(seen), 32'd0);
    run_one("rm_new", 32'h0F0F0F0F, 5'd4, 2'b01, 32'hF0F0F0F0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
